peripheral_bcd_display: RTL



---
 rtl/display_pkg.sv | 42 ++++
 rtl/peripheral_bcd_display_if.sv | 22 ++
 rtl/peripheral_bcd_display_bcd_to_seg.sv | 26 ++
 rtl/peripheral_bcd_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, register map, glyphs and control layout for the BCD display peripheral.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SHADOW_W   = NUM_DIGITS * DIGIT_W;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RDATA_W    = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;

  localparam logic [ADDR_W-1:0] ADDR_DIGITS_LO = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_DIGITS_HI = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'h0C;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_BLANK_BIT  = 1;
  localparam int unsigned CTRL_BLINK_BIT  = 2;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

  typedef struct packed {
    logic blink;
    logic blank;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/peripheral_bcd_display_if.sv
// CPU register bus between the host and the BCD display peripheral.
interface peripheral_bcd_display_if;
  import display_pkg::*;

  logic [DATA_W-1:0]  data_input;
  logic               chip_select;
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic               write;
  logic [RDATA_W-1:0] data_output;

  modport master (
    output data_input, chip_select, address, read, write,
    input  data_output
  );

  modport slave (
    input  data_input, chip_select, address, read, write,
    output data_output
  );

endinterface

// File: rtl/peripheral_bcd_display_bcd_to_seg.sv
// Combinational nibble to active-low seven-segment glyph; A-F show a dash.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/peripheral_bcd_display.sv
// Double-buffered five-digit multiplexed seven-segment driver with register interface.
// Optional blinking is built when DISPLAY_BLINK_EN is defined.
module peripheral_bcd_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  peripheral_bcd_display_if.slave bus,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 2) begin : g_div_check
    $error("REFRESH_DIV must be at least 2");
  end
  if (BLINK_TICKS < 1) begin : g_blink_check
    $error("BLINK_TICKS must be at least 1");
  end

  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [SHADOW_W-1:0]   shadow;
  logic [SHADOW_W-1:0]   active;
  ctrl_t                 ctrl;
  logic                  pending;

  logic                  tick_c;
  logic                  commit_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  digit_wr_c;
  logic [RDATA_W-1:0]    rdata_c;
  logic [DIGIT_W-1:0]    digit_c;
  logic                  blanked_c;
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic                  zero_run_c;
  logic [SEG_W-1:0]      glyph_c;
  logic [SEG_W-1:0]      seg_next_c;
  logic [NUM_DIGITS-1:0] anode_next_c;

  assign tick_c     = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign wr_c       = bus.chip_select & bus.write;
  assign rd_c       = bus.chip_select & bus.read & ~bus.write;
  assign digit_wr_c = wr_c & ((bus.address == ADDR_DIGITS_LO) | (bus.address == ADDR_DIGITS_HI));
  // Frame-boundary commit, or continuous follow while the display is off
  assign commit_c   = ~ctrl.enable | (tick_c & (scan_idx == IDX_W'(NUM_DIGITS - 1)));

  always_comb begin
    rdata_c = '0;
    case (bus.address)
      ADDR_DIGITS_LO: rdata_c[DATA_W-1:0]  = shadow[DATA_W-1:0];
      ADDR_DIGITS_HI: rdata_c[DIGIT_W-1:0] = shadow[SHADOW_W-1:DATA_W];
      ADDR_CTRL:      rdata_c[2:0]         = ctrl;
      ADDR_STATUS:    rdata_c[IDX_W:0]     = {scan_idx, pending};
      default:        rdata_c = '0;
    endcase
  end

  // Zero run from the top digit down; digit 0 always shows
  always_comb begin
    lead_zero_c = '0;
    zero_run_c  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run_c     = zero_run_c & (active[i*DIGIT_W +: DIGIT_W] == '0);
      lead_zero_c[i] = zero_run_c;
    end
  end

  always_comb begin
    digit_c   = active[DIGIT_W-1:0];
    blanked_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        digit_c   = active[i*DIGIT_W +: DIGIT_W];
        blanked_c = ctrl.blank & lead_zero_c[i];
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (digit_c),
    .seg_c  (glyph_c)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               blink_hide;
  logic               blink_wrap_c;

  assign blink_wrap_c = (blink_cnt == BLINK_W'(BLINK_TICKS - 1));

  // Hide decision is latched per tick so it lines up with slot changes
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_hide  <= 1'b0;
    end else if (tick_c) begin
      blink_cnt   <= blink_wrap_c ? '0 : blink_cnt + BLINK_W'(1);
      blink_phase <= blink_phase ^ blink_wrap_c;
      blink_hide  <= ctrl.blink & (blink_phase ^ blink_wrap_c);
    end
  end
`else
  logic blink_hide;
  assign blink_hide = 1'b0;
`endif

  always_comb begin
    anode_next_c = '1;
    seg_next_c   = SEG_OFF;
    if (ctrl.enable && !blanked_c) begin
      anode_next_c = ~(NUM_DIGITS'(1) << scan_idx);
      seg_next_c   = glyph_c;
      if (blink_hide) begin
        anode_next_c = '1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt     <= '0;
      scan_idx        <= '0;
      shadow          <= '0;
      active          <= '0;
      ctrl            <= '0;
      pending         <= 1'b0;
      bus.data_output <= '0;
      anode           <= '1;
      seg             <= SEG_OFF;
    end else begin
      refresh_cnt <= tick_c ? '0 : refresh_cnt + CNT_W'(1);
      if (tick_c) begin
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end
      if (commit_c) begin
        active <= shadow;
      end
      if (digit_wr_c) begin
        pending <= 1'b1;
      end else if (commit_c) begin
        pending <= 1'b0;
      end
      if (wr_c) begin
        case (bus.address)
          ADDR_DIGITS_LO: shadow[DATA_W-1:0]        <= bus.data_input;
          ADDR_DIGITS_HI: shadow[SHADOW_W-1:DATA_W] <= bus.data_input[DIGIT_W-1:0];
          ADDR_CTRL: begin
            ctrl.enable <= bus.data_input[CTRL_ENABLE_BIT];
            ctrl.blank  <= bus.data_input[CTRL_BLANK_BIT];
`ifdef DISPLAY_BLINK_EN
            ctrl.blink  <= bus.data_input[CTRL_BLINK_BIT];
`endif
          end
          default: ;
        endcase
      end
      if (rd_c) begin
        bus.data_output <= rdata_c;
      end
      anode <= anode_next_c;
      seg   <= seg_next_c;
    end
  end

endmodule
